// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of four word requesters onto one VALID/READY consumer
module mux4_rr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic             ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] y,
    output logic             xfer
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] HMAX = 4'(HOLD_MAX);
    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] win;
    logic [3:0] cnt_nxt;
    logic       release_now;
    logic [WIDTH-1:0] word;
    always_comb begin
        win = req[ptr] ? ptr :
              req[ptr + 2'd1] ? ptr + 2'd1 :
              req[ptr + 2'd2] ? ptr + 2'd2 : ptr + 2'd3;
        cnt_nxt = cnt + 4'd1;
        // a transfer ends the burst unless the owner still requests and has budget left
        release_now = xfer ? !(req[sel] && cnt_nxt < HMAX) : !req[sel];
        word = sel[1] ? (sel[0] ? a3 : a2) : (sel[0] ? a1 : a0);
    end
    assign y    = valid ? word : '0;
    assign xfer = valid & ready;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            gnt   <= 4'd0;
            valid <= 1'b0;
            cnt   <= 4'd0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= BUSY;
                sel   <= win;
                gnt   <= 4'b0001 << win;
                valid <= 1'b1;
                cnt   <= 4'd0;
            end
        end else if (release_now) begin
            state <= IDLE;
            gnt   <= 4'd0;
            valid <= 1'b0;
            ptr   <= sel + 2'd1;
            cnt   <= 4'd0;
        end else if (xfer) begin
            cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for the round-robin word arbiter
module tb_mux4_rr_arbiter;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [3:0]  req4 = 4'd0, req1 = 4'd0;
    logic        rdy4 = 1'b0, rdy1 = 1'b0;
    logic [31:0] a0 = 32'h0, a1 = 32'h1, a2 = 32'h10, a3 = 32'h11;
    logic [3:0]  g4, g1;
    logic [1:0]  s4, s1;
    logic        v4, v1, x4, x1;
    logic [31:0] y4, y1;
    int          total = 0, passed = 0;
    typedef struct {
        bit          d;
        string       tag;
        logic [3:0]  g;
        int          s;
        logic        v;
        logic [31:0] y;
        logic        x;
    } exp_t;
    exp_t q[$];
    logic [31:0] dv[4] = '{32'h0, 32'h1, 32'h10, 32'h11};

    mux4_rr_arbiter #(.WIDTH(32), .HOLD_MAX(4)) dut4 (
        .clk(clk), .clrn(clrn), .req(req4), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .ready(rdy4), .gnt(g4), .sel(s4), .valid(v4), .y(y4), .xfer(x4)
    );
    mux4_rr_arbiter #(.WIDTH(32), .HOLD_MAX(1)) dut1 (
        .clk(clk), .clrn(clrn), .req(req1), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .ready(rdy1), .gnt(g1), .sel(s1), .valid(v1), .y(y1), .xfer(x1)
    );

    always #5 clk = ~clk;

    task automatic ex(input bit d, input string tag, input logic [3:0] g, input int s,
                      input logic v, input logic [31:0] yy, input logic x);
        exp_t e;
        e.d = d; e.tag = tag; e.g = g; e.s = s; e.v = v; e.y = yy; e.x = x;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".gnt"},   32'(e.d ? g1 : g4), 32'(e.g));
            if (e.s >= 0) chk({e.tag, ".sel"}, 32'(e.d ? s1 : s4), 32'(e.s));
            chk({e.tag, ".valid"}, 32'(e.d ? v1 : v4), 32'(e.v));
            chk({e.tag, ".y"},     e.d ? y1 : y4, e.y);
            chk({e.tag, ".xfer"},  32'(e.d ? x1 : x4), 32'(e.x));
        end
    endtask

    task automatic cyc();
        sample();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2;
        ex(0, "rst", 4'd0, 0, 0, 0, 0); ex(1, "rst1", 4'd0, 0, 0, 0, 0); cyc();
        clrn = 1'b1;
        // single burst of HOLD_MAX words, bubble, then regrant of the same requester
        req4 = 4'b0010; rdy4 = 1'b1;
        ex(0, "t2.idle", 4'd0, -1, 0, 0, 0); cyc();
        for (int i = 0; i < 4; i++) begin
            ex(0, "t2.burst", 4'b0010, 1, 1, 32'h1, 1); cyc();
        end
        ex(0, "t2.bubble", 4'd0, -1, 0, 0, 0); cyc();
        req4 = 4'd0;
        ex(0, "t2.regrant", 4'b0010, 1, 1, 32'h1, 1); cyc();
        // reset mid-burst with sel=2, cnt=2
        req4 = 4'b0100;
        ex(0, "t1.idle", 4'd0, -1, 0, 0, 0); cyc();
        ex(0, "t1.b0", 4'b0100, 2, 1, 32'h10, 1); cyc();
        ex(0, "t1.b1", 4'b0100, 2, 1, 32'h10, 1); cyc();
        clrn = 1'b0;
        ex(0, "t1.rst", 4'd0, 0, 0, 0, 0); cyc();
        clrn = 1'b1;
        ex(0, "t1.after", 4'd0, 0, 0, 0, 0); cyc();
        // withdraw while stalled
        req4 = 4'd0; rdy4 = 1'b0;
        ex(0, "t5.stall", 4'b0100, 2, 1, 32'h10, 0); cyc();
        req4 = 4'b0101;
        ex(0, "t5.idle", 4'd0, -1, 0, 0, 0); cyc();
        req4 = 4'd0;
        ex(0, "t5.gnt0", 4'b0001, 0, 1, 32'h0, 0); cyc();
        // backpressure: five stalled cycles, then a full burst
        req4 = 4'b1000;
        ex(0, "t4.idle", 4'd0, -1, 0, 0, 0); cyc();
        for (int i = 0; i < 5; i++) begin
            ex(0, "t4.stall", 4'b1000, 3, 1, 32'h11, 0); cyc();
        end
        rdy4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex(0, "t4.xfer", 4'b1000, 3, 1, 32'h11, 1); cyc();
        end
        req4 = 4'd0;
        ex(0, "t4.rel", 4'd0, -1, 0, 0, 0); cyc();
        // pointer wrap 3 -> 0
        req4 = 4'b0100; rdy4 = 1'b0;
        ex(0, "t6.idle0", 4'd0, -1, 0, 0, 0); cyc();
        req4 = 4'd0;
        ex(0, "t6.wd", 4'b0100, 2, 1, 32'h10, 0); cyc();
        req4 = 4'b1001; rdy4 = 1'b1;
        ex(0, "t6.idle1", 4'd0, -1, 0, 0, 0); cyc();
        for (int i = 0; i < 4; i++) begin
            ex(0, "t6.g3", 4'b1000, 3, 1, 32'h11, 1); cyc();
        end
        ex(0, "t6.idle2", 4'd0, -1, 0, 0, 0); cyc();
        req4 = 4'd0;
        ex(0, "t6.g0", 4'b0001, 0, 1, 32'h0, 1); cyc();
        // round robin with single-word bursts
        req1 = 4'b1111; rdy1 = 1'b1;
        ex(1, "t3.idle", 4'd0, -1, 0, 0, 0); cyc();
        for (int k = 0; k < 5; k++) begin
            ex(1, "t3.busy", 4'(1 << (k % 4)), k % 4, 1, dv[k % 4], 1); cyc();
            if (k < 4) begin
                ex(1, "t3.bubble", 4'd0, -1, 0, 0, 0); cyc();
            end
        end
        req1 = 4'd0;
        sample();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
